// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the MIPS data-memory responder.
package mips_mem_pkg;
  localparam int WORD_W         = 32;
  localparam int DEF_ADDR_W     = 6;
  localparam int DEF_WBUF_DEPTH = 4;

  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] idx;
    logic [WORD_W-1:0]     data;
  } wbuf_entry_t;

  function automatic logic word_aligned(input logic [1:0] byte_off);
    return byte_off == 2'b00;
  endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// CPU data port plus loader write port of the data-memory responder.
interface dmem_responder_if
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int WBUF_DEPTH = DEF_WBUF_DEPTH
);
  logic                          memwrite;
  logic [WORD_W-1:0]             addr;
  logic [WORD_W-1:0]             writedata;
  logic [WORD_W-1:0]             readdata;
  logic                          ld_valid;
  logic                          ld_ready;
  logic [ADDR_W-1:0]             ld_addr;
  logic [WORD_W-1:0]             ld_data;
  logic [$clog2(WBUF_DEPTH):0]   wbuf_count;
  logic                          misaligned;

  modport master (
    output memwrite, addr, writedata, ld_valid, ld_addr, ld_data,
    input  readdata, ld_ready, wbuf_count, misaligned
  );
  modport slave (
    input  memwrite, addr, writedata, ld_valid, ld_addr, ld_data,
    output readdata, ld_ready, wbuf_count, misaligned
  );
endinterface

// File: rtl/wbuf_fifo.sv
// Circular store buffer: push/pop with count, plus youngest-entry match lookup.
// Push and pop may coincide when full; the freed head slot takes the new entry.
module wbuf_fifo
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_WBUF_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push_i,
  input  logic [ADDR_W-1:0]         push_idx_i,
  input  logic [WORD_W-1:0]         push_dat_i,
  input  logic                      pop_i,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic [ADDR_W-1:0]         head_idx_o,
  output logic [WORD_W-1:0]         head_dat_o,
  input  logic [ADDR_W-1:0]         q_idx_i,
  output logic                      hit_o,
  output logic [WORD_W-1:0]         hit_dat_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] idx;
    logic [WORD_W-1:0] data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   slot;

  always_comb count_d = count_q + CW'(push_i) - CW'(pop_i);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (pop_i) begin
        mem_q[rd_ptr_q].valid <= 1'b0;
        rd_ptr_q              <= rd_ptr_q + PW'(1);
      end
      // Placed after the pop so a push into the just-freed head slot wins.
      if (push_i) begin
        mem_q[wr_ptr_q] <= '{valid: 1'b1, idx: push_idx_i, data: push_dat_i};
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  // Occupied slots are contiguous from the head, so walking oldest to youngest
  // leaves the youngest match in place.
  always_comb begin
    hit_o     = 1'b0;
    hit_dat_o = '0;
    slot      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_ptr_q + PW'(k);
      if (mem_q[slot].valid && mem_q[slot].idx == q_idx_i) begin
        hit_o     = 1'b1;
        hit_dat_o = mem_q[slot].data;
      end
    end
  end

  assign count_o    = count_q;
  assign head_idx_o = mem_q[rd_ptr_q].idx;
  assign head_dat_o = mem_q[rd_ptr_q].data;
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM, non-blocking store buffer, loader write port.
// Loader owns the RAM write port unless the buffer is full; loads forward from the buffer.
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int WBUF_DEPTH = DEF_WBUF_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  dmem_responder_if.slave bus
);
  localparam int CW = $clog2(WBUF_DEPTH) + 1;

  logic [WORD_W-1:0] ram_q [2**ADDR_W];
  logic [ADDR_W-1:0] cpu_idx;
  logic [ADDR_W-1:0] head_idx;
  logic [WORD_W-1:0] head_dat, hit_dat;
  logic [CW-1:0]     count;
  logic              hit, full, ld_fire, drain, store_ok;
  logic              misaligned_q, misaligned_d;
  logic              unused_addr_hi;

  assign cpu_idx        = bus.addr[ADDR_W+1:2];
  assign unused_addr_hi = ^bus.addr[WORD_W-1:ADDR_W+2];

  assign store_ok = bus.memwrite && word_aligned(bus.addr[1:0]);
  assign full     = count == CW'(WBUF_DEPTH);
  assign ld_fire  = bus.ld_valid && !full;
  assign drain    = !ld_fire && count != '0;

  wbuf_fifo #(.ADDR_W(ADDR_W), .DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk        (clk),
    .reset      (reset),
    .push_i     (store_ok),
    .push_idx_i (cpu_idx),
    .push_dat_i (bus.writedata),
    .pop_i      (drain),
    .count_o    (count),
    .head_idx_o (head_idx),
    .head_dat_o (head_dat),
    .q_idx_i    (cpu_idx),
    .hit_o      (hit),
    .hit_dat_o  (hit_dat)
  );

  // Single RAM write port, contents intentionally not reset.
  always_ff @(posedge clk) begin
    if (ld_fire) begin
      ram_q[bus.ld_addr] <= bus.ld_data;
    end else if (drain) begin
      ram_q[head_idx] <= head_dat;
    end
  end

  always_comb misaligned_d = misaligned_q || (bus.memwrite && !word_aligned(bus.addr[1:0]));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) misaligned_q <= 1'b0;
    else        misaligned_q <= misaligned_d;
  end

  assign bus.readdata   = hit ? hit_dat : ram_q[cpu_idx];
  assign bus.ld_ready   = !full;
  assign bus.wbuf_count = count;
  assign bus.misaligned = misaligned_q;
endmodule
